snail_fsm_mealey_unique_11: RTL and testbench
=============================================

SNAIL_FSM_MEALEY_UNIQUE_11 -- requirements
Module: snail_fsm_mealey_unique_11

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 _rst  input  1  reset, synchronous and active-high (1 = reset, sampled on rising clk).
REQ-004 D  input  1  serial data bit, one bit consumed per rising clk.
REQ-005 Q  output  1  Mealey detect flag, combinational from current state and D.
REQ-006 The block SHALL contain an internal 64-bit signal named txstate, readable hierarchically by benches, holding the current state name as 8 ASCII characters: right-justified, zero-padded on the left.

Function
REQ-007 The block SHALL be a Mealey-type overlapping detector for the serial pattern 1-1-0-1, oldest bit first.
REQ-008 The states SHALL be IDLE (no useful prefix), GOT1 (prefix "1"), GOT11 (prefix "11") and GOT110 (prefix "110"); encoding is 2-bit binary, 00/01/10/11 respectively.
REQ-009 IDLE: D=1 -> GOT1; D=0 -> IDLE; Q=0.
REQ-010 GOT1: D=1 -> GOT11; D=0 -> IDLE; Q=0.
REQ-011 GOT11: D=1 -> GOT11; D=0 -> GOT110; Q=0.
REQ-012 GOT110: D=1 -> GOT1 with Q=1; D=0 -> IDLE with Q=0.
REQ-013 Q SHALL be 1 exactly when state is GOT110 and D=1 and _rst=0, with zero-cycle latency (same cycle as the fourth pattern bit, before the clock edge).
REQ-014 Overlap: the final "1" of a detected pattern SHALL count as the first "1" of the next pattern (e.g. 1101101 yields two detects).
REQ-015 Q SHALL follow D combinationally within a cycle; any glitch or change of D mid-cycle is reflected on Q, and only the value at the rising edge affects the state.
REQ-016 txstate SHALL be combinational from the state register: "IDLE", "GOT1", "GOT11", "GOT110".
REQ-017 Unreachable or X state values SHALL return to IDLE on the next clock edge; txstate shows "UNKNOWN" for such values.
REQ-018 The block SHALL contain no other storage than the 2-bit state register.

Reset
REQ-019 When _rst=1 at a rising clk edge, the state SHALL become IDLE regardless of D and of the current state.
REQ-020 While _rst=1, Q SHALL be forced to 0 regardless of state and D.
REQ-021 Reset SHALL have no asynchronous effect: a _rst pulse that does not span a rising clk edge SHALL leave the state unchanged.
REQ-022 A reset asserted mid-pattern, including in GOT110, SHALL discard the partial prefix; detection restarts from the first bit sampled with _rst=0.
REQ-023 State before the first reset edge is undefined; a bench SHALL apply reset for at least one rising edge before checking.

Verification
REQ-024 Reset held 1 for 2 edges with D=1 -> state IDLE, txstate "IDLE", Q=0 throughout.
REQ-025 _rst=0, D sequence 1,1,0,1 sampled on 4 edges -> states GOT1, GOT11, GOT110, then Q=1 during the 4th bit before its edge, and state GOT1 after it.
REQ-026 D sequence 1,1,0,1,1,0,1 -> Q=1 during bit 4 and bit 7 only (overlap), 0 elsewhere.
REQ-027 D sequence 1,1,1,1,0,1 -> stays GOT11 through the extra 1s, Q=1 only during bit 6; sequence 1,1,0,0,1 -> returns to IDLE after bit 4, Q never 1.
REQ-028 In GOT110, assert _rst=1 with D=1 -> Q=0 in that cycle, state IDLE after the edge; then D=1 -> GOT1, not a detect.
REQ-029 Random D for 30 cycles with _rst=0 -> Q and state match a reference model built from REQ-009..REQ-014 each cycle.

Source files
------------

// File: rtl/snail_fsm_mealey_unique_11.sv
// Overlapping Mealy detector for the serial pattern 1-1-0-1, oldest bit first.
// Q is combinational from the current state and D, so a detect shows up in the
// same cycle as the final pattern bit, before the clock edge that consumes it.
// The 2-bit state register is the only storage in this block.
module snail_fsm_mealey_unique_11 (
  input  logic clk,
  input  logic _rst,
  input  logic D,
  output logic Q
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGot1   = 2'b01,
    StGot11  = 2'b10,
    StGot110 = 2'b11
  } state_e;

  state_e state_q;
  state_e state_d;

  // Current state name as right-justified, zero-padded ASCII, for hierarchical observation.
  logic [63:0] txstate;

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy output; any unreachable or X state falls back to idle.
  always_comb begin
    state_d = StIdle;
    Q       = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = D ? StGot1 : StIdle;
      end
      StGot1: begin
        state_d = D ? StGot11 : StIdle;
      end
      StGot11: begin
        // Extra leading 1s keep the "11" prefix alive.
        state_d = D ? StGot11 : StGot110;
      end
      StGot110: begin
        // The closing 1 also opens the next pattern (overlap).
        state_d = D ? StGot1 : StIdle;
        Q       = D & ~_rst;
      end
      default: begin
        state_d = StIdle;
        Q       = 1'b0;
      end
    endcase
  end

  // Decode the state register into its printable name.
  always_comb begin
    txstate = {8'h00, "UNKNOWN"};
    case (state_q)
      StIdle:   txstate = {32'h0, "IDLE"};
      StGot1:   txstate = {32'h0, "GOT1"};
      StGot11:  txstate = {24'h0, "GOT11"};
      StGot110: txstate = {16'h0, "GOT110"};
      default:  txstate = {8'h00, "UNKNOWN"};
    endcase
  end

  // txstate has no consumer inside the block; fold it into a named sink.
  logic unused_txstate;
  assign unused_txstate = ^txstate;

endmodule

// File: tb/tb_snail_fsm_mealey_unique_11.sv
// Directed bench for the 1101 Mealy detector, plus a short random run against a small model.
module tb_snail_fsm_mealey_unique_11;

  logic clk = 1'b0;
  logic _rst = 1'b1;
  logic D = 1'b0;
  logic Q;

  localparam logic [63:0] TxIdle   = {32'h0, "IDLE"};
  localparam logic [63:0] TxGot1   = {32'h0, "GOT1"};
  localparam logic [63:0] TxGot11  = {24'h0, "GOT11"};
  localparam logic [63:0] TxGot110 = {16'h0, "GOT110"};

  int n_checks = 0;
  int n_fail   = 0;

  snail_fsm_mealey_unique_11 dut (
    .clk  (clk),
    ._rst (_rst),
    .D    (D),
    .Q    (Q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit at the falling edge, check Q before the rising edge, then the state after it.
  task automatic step(input string tag, input logic rst, input logic d, input logic exp_q,
                      input logic [63:0] exp_st);
    @(negedge clk);
    _rst = rst;
    D    = d;
    #1;
    check({tag, ".q"}, {63'h0, Q}, {63'h0, exp_q});
    @(posedge clk);
    #1;
    check({tag, ".st"}, dut.txstate, exp_st);
  endtask

  // Reference model: 0=IDLE 1=GOT1 2=GOT11 3=GOT110.
  function automatic int model_next(input int s, input logic d);
    case (s)
      0:       return d ? 1 : 0;
      1:       return d ? 2 : 0;
      2:       return d ? 2 : 3;
      3:       return d ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_name(input int s);
    case (s)
      0:       return TxIdle;
      1:       return TxGot1;
      2:       return TxGot11;
      default: return TxGot110;
    endcase
  endfunction

  initial begin
    int m;
    logic d;
    logic eq;

    // Reset for two edges with D=1.
    step("rst_a", 1'b1, 1'b1, 1'b0, TxIdle);
    step("rst_b", 1'b1, 1'b1, 1'b0, TxIdle);

    // Basic 1101 detect.
    step("p1", 1'b0, 1'b1, 1'b0, TxGot1);
    step("p2", 1'b0, 1'b1, 1'b0, TxGot11);
    step("p3", 1'b0, 1'b0, 1'b0, TxGot110);
    step("p4", 1'b0, 1'b1, 1'b1, TxGot1);

    // Overlap 1101101.
    step("ov_rst", 1'b1, 1'b0, 1'b0, TxIdle);
    step("ov1", 1'b0, 1'b1, 1'b0, TxGot1);
    step("ov2", 1'b0, 1'b1, 1'b0, TxGot11);
    step("ov3", 1'b0, 1'b0, 1'b0, TxGot110);
    step("ov4", 1'b0, 1'b1, 1'b1, TxGot1);
    step("ov5", 1'b0, 1'b1, 1'b0, TxGot11);
    step("ov6", 1'b0, 1'b0, 1'b0, TxGot110);
    step("ov7", 1'b0, 1'b1, 1'b1, TxGot1);

    // Long run of 1s: 111101.
    step("l_rst", 1'b1, 1'b0, 1'b0, TxIdle);
    step("l1", 1'b0, 1'b1, 1'b0, TxGot1);
    step("l2", 1'b0, 1'b1, 1'b0, TxGot11);
    step("l3", 1'b0, 1'b1, 1'b0, TxGot11);
    step("l4", 1'b0, 1'b1, 1'b0, TxGot11);
    step("l5", 1'b0, 1'b0, 1'b0, TxGot110);
    step("l6", 1'b0, 1'b1, 1'b1, TxGot1);

    // Broken pattern 11001.
    step("b_rst", 1'b1, 1'b0, 1'b0, TxIdle);
    step("b1", 1'b0, 1'b1, 1'b0, TxGot1);
    step("b2", 1'b0, 1'b1, 1'b0, TxGot11);
    step("b3", 1'b0, 1'b0, 1'b0, TxGot110);
    step("b4", 1'b0, 1'b0, 1'b0, TxIdle);
    step("b5", 1'b0, 1'b1, 1'b0, TxGot1);

    // Reset in GOT110 with D=1 masks the detect and discards the prefix.
    step("r_rst", 1'b1, 1'b0, 1'b0, TxIdle);
    step("r1", 1'b0, 1'b1, 1'b0, TxGot1);
    step("r2", 1'b0, 1'b1, 1'b0, TxGot11);
    step("r3", 1'b0, 1'b0, 1'b0, TxGot110);
    step("r4", 1'b1, 1'b1, 1'b0, TxIdle);
    step("r5", 1'b0, 1'b1, 1'b0, TxGot1);

    // Reset pulse that does not span an edge leaves the state alone.
    step("a1", 1'b0, 1'b1, 1'b0, TxGot11);
    @(negedge clk);
    D    = 1'b0;
    _rst = 1'b1;
    #1;
    check("apulse.q", {63'h0, Q}, 64'h0);
    #1;
    _rst = 1'b0;
    #1;
    check("apulse.st", dut.txstate, TxGot11);
    @(posedge clk);
    #1;
    check("apulse.next", dut.txstate, TxGot110);

    // Q tracks D mid-cycle in GOT110; only the edge value of D moves the state.
    @(negedge clk);
    D = 1'b1;
    #1;
    check("glitch.hi1", {63'h0, Q}, 64'h1);
    D = 1'b0;
    #1;
    check("glitch.lo", {63'h0, Q}, 64'h0);
    D = 1'b1;
    #1;
    check("glitch.hi2", {63'h0, Q}, 64'h1);
    @(posedge clk);
    #1;
    check("glitch.st", dut.txstate, TxGot1);

    // Random run against the model.
    step("rnd_rst", 1'b1, 1'b0, 1'b0, TxIdle);
    m = 0;
    for (int i = 0; i < 30; i++) begin
      d  = 1'($urandom_range(0, 1));
      eq = (m == 3) && d;
      m  = model_next(m, d);
      step("rnd", 1'b0, d, eq, model_name(m));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
